// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM access arbiter: FSM states and grant encodings.
package sdram_arb_pkg;

    localparam logic [1:0] GNT_NONE_ENC = 2'b00;
    localparam logic [1:0] GNT_WR_ENC   = 2'b01;
    localparam logic [1:0] GNT_RD_ENC   = 2'b10;

    typedef enum logic [1:0] {
        GNT_NONE = GNT_NONE_ENC,
        GNT_WR   = GNT_WR_ENC,
        GNT_RD   = GNT_RD_ENC
    } grant_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        XFER_WR,
        XFER_RD,
        DONE
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_priority.sv
// Combinational burst-boundary pick: starved writer, then urgent reader,
// then round-robin against the previous winner, then the lone requester.
module sdram_arb_priority
    import sdram_arb_pkg::*;
(
    input  logic   i_wr_req,
    input  logic   i_rd_req,
    input  logic   i_rd_urgent,
    input  logic   i_starved,
    input  grant_t i_last_grant,
    output grant_t o_grant
);

    always_comb begin
        o_grant = GNT_NONE;
        if (i_wr_req && i_starved) begin
            o_grant = GNT_WR;
        end else if (i_rd_req && i_rd_urgent) begin
            o_grant = GNT_RD;
        end else if (i_wr_req && i_rd_req) begin
            o_grant = (i_last_grant == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (i_wr_req) begin
            o_grant = GNT_WR;
        end else if (i_rd_req) begin
            o_grant = GNT_RD;
        end
    end

endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares one SDRAM controller between the camera writer and the VGA reader,
// one command per burst, with reader urgency and a writer starvation guard.
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 22,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_sdram,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_data_ack,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic                  rd_urgent,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_done,
    output logic                  ctl_cmd_valid,
    output logic                  ctl_cmd_write,
    output logic [ADDR_WIDTH-1:0] ctl_cmd_addr,
    input  logic                  ctl_cmd_ready,
    output logic [DATA_WIDTH-1:0] ctl_wr_data,
    input  logic                  ctl_wr_data_ack,
    input  logic                  ctl_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] ctl_rd_data,
    output logic [1:0]            grant,
    output logic                  protocol_err
);

    localparam int unsigned WCW = $clog2(BURST_LEN) + 1;
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(BURST_LEN - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    arb_state_t            r_state;
    grant_t                r_grant;
    grant_t                r_last_grant;
    logic [SCW-1:0]        r_starve_cnt;
    logic [WCW-1:0]        r_word_cnt;
    logic                  r_cmd_valid;
    logic                  r_cmd_write;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic                  r_rd_data_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_wr_done;
    logic                  r_rd_done;
    logic                  r_protocol_err;

    grant_t w_pick;
    logic   w_starved;
    logic   w_in_wr;
    logic   w_in_rd;

    assign w_starved = (r_starve_cnt == STARVE_MAX);
    assign w_in_wr   = (r_state == XFER_WR);
    assign w_in_rd   = (r_state == XFER_RD);

    sdram_arb_priority u_priority (
        .i_wr_req     (wr_req),
        .i_rd_req     (rd_req),
        .i_rd_urgent  (rd_urgent),
        .i_starved    (w_starved),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    always_ff @(posedge clk_sdram) begin
        if (rst) begin
            r_state         <= IDLE;
            r_grant         <= GNT_NONE;
            r_last_grant    <= GNT_RD;
            r_starve_cnt    <= '0;
            r_word_cnt      <= '0;
            r_cmd_valid     <= 1'b0;
            r_cmd_write     <= 1'b0;
            r_cmd_addr      <= '0;
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
            r_wr_done       <= 1'b0;
            r_rd_done       <= 1'b0;
            r_protocol_err  <= 1'b0;
        end else begin
            r_rd_data_valid <= 1'b0;
            r_wr_done       <= 1'b0;
            r_rd_done       <= 1'b0;

            // Controller data outside its transfer phase is dropped but remembered.
            if ((ctl_rd_data_valid && !w_in_rd) || (ctl_wr_data_ack && !w_in_wr)) begin
                r_protocol_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick != GNT_NONE) begin
                        r_grant     <= w_pick;
                        r_cmd_valid <= 1'b1;
                        r_cmd_write <= (w_pick == GNT_WR);
                        r_cmd_addr  <= (w_pick == GNT_WR) ? wr_addr : rd_addr;
                        if (w_pick == GNT_WR) begin
                            r_starve_cnt <= '0;
                        end else if (wr_req && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + SCW'(1);
                        end
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (ctl_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= r_cmd_write ? XFER_WR : XFER_RD;
                    end
                end
                XFER_WR: begin
                    if (ctl_wr_data_ack) begin
                        if (r_word_cnt == LAST_WORD) begin
                            r_word_cnt <= '0;
                            r_wr_done  <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + WCW'(1);
                        end
                    end
                end
                XFER_RD: begin
                    r_rd_data_valid <= ctl_rd_data_valid;
                    if (ctl_rd_data_valid) begin
                        r_rd_data <= ctl_rd_data;
                        if (r_word_cnt == LAST_WORD) begin
                            r_word_cnt <= '0;
                            r_rd_done  <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + WCW'(1);
                        end
                    end
                end
                DONE: begin
                    r_last_grant <= r_grant;
                    r_grant      <= GNT_NONE;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ctl_wr_data   = w_in_wr ? wr_data : '0;
    assign wr_data_ack   = w_in_wr && ctl_wr_data_ack;
    assign wr_done       = r_wr_done;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_data       = r_rd_data;
    assign rd_done       = r_rd_done;
    assign ctl_cmd_valid = r_cmd_valid;
    assign ctl_cmd_write = r_cmd_write;
    assign ctl_cmd_addr  = r_cmd_addr;
    assign grant         = r_grant;
    assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Randomized burst-level bench: the bench plays both requesters and the
// controller, and predicts winners from the arbitration rules.
module tb_sdram_access_arbiter;

    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 16;
    localparam int unsigned BL    = 8;
    localparam int unsigned LIMIT = 4;

    logic          clk_sdram = 1'b0;
    logic          rst;
    logic          wr_req, rd_req, rd_urgent;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_data_ack, wr_done;
    logic          rd_data_valid, rd_done;
    logic [DW-1:0] rd_data;
    logic          ctl_cmd_valid, ctl_cmd_write, ctl_cmd_ready;
    logic [AW-1:0] ctl_cmd_addr;
    logic [DW-1:0] ctl_wr_data, ctl_rd_data;
    logic          ctl_wr_data_ack, ctl_rd_data_valid;
    logic [1:0]    grant;
    logic          protocol_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: bursts the writer has lost in a row, previous winner.
    int m_starve  = 0;
    bit m_last_wr = 1'b0;

    always #5 clk_sdram = ~clk_sdram;

    sdram_access_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BURST_LEN    (BL),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_sdram         (clk_sdram),
        .rst               (rst),
        .wr_req            (wr_req),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_data_ack       (wr_data_ack),
        .wr_done           (wr_done),
        .rd_req            (rd_req),
        .rd_urgent         (rd_urgent),
        .rd_addr           (rd_addr),
        .rd_data_valid     (rd_data_valid),
        .rd_data           (rd_data),
        .rd_done           (rd_done),
        .ctl_cmd_valid     (ctl_cmd_valid),
        .ctl_cmd_write     (ctl_cmd_write),
        .ctl_cmd_addr      (ctl_cmd_addr),
        .ctl_cmd_ready     (ctl_cmd_ready),
        .ctl_wr_data       (ctl_wr_data),
        .ctl_wr_data_ack   (ctl_wr_data_ack),
        .ctl_rd_data_valid (ctl_rd_data_valid),
        .ctl_rd_data       (ctl_rd_data),
        .grant             (grant),
        .protocol_err      (protocol_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_bundle();
        return {1'b0, ctl_cmd_valid, ctl_cmd_write, ctl_cmd_addr, grant, rd_data_valid,
                rd_data, rd_done, wr_done, wr_data_ack, ctl_wr_data, protocol_err};
    endfunction

    task automatic drive_idle();
        wr_req = 0; rd_req = 0; rd_urgent = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        ctl_cmd_ready = 0; ctl_wr_data_ack = 0; ctl_rd_data_valid = 0; ctl_rd_data = '0;
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        rst = 1;
        @(negedge clk_sdram);
        @(negedge clk_sdram);
        rst = 0;
        check_eq(tag, out_bundle(), 64'd0);
        m_starve  = 0;
        m_last_wr = 1'b0;
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic run_burst(input bit wr, input bit rd, input bit urg, input int delay,
                             input int abort_words);
        bit            win_wr;
        logic [AW-1:0] wa, ra, exp_addr;
        logic [DW-1:0] d;
        bit            v;
        int            n, cyc;

        if (wr && m_starve == LIMIT)  win_wr = 1'b1;
        else if (rd && urg)           win_wr = 1'b0;
        else if (wr && rd)            win_wr = !m_last_wr;
        else                          win_wr = wr;

        wa = AW'($urandom);
        ra = AW'($urandom);
        exp_addr = win_wr ? wa : ra;
        wr_req = wr; rd_req = rd; rd_urgent = urg; wr_addr = wa; rd_addr = ra;
        ctl_cmd_ready = 0;
        @(negedge clk_sdram);
        wr_req = 0; rd_req = 0; rd_urgent = 0;
        wr_addr = AW'($urandom); rd_addr = AW'($urandom);
        check_eq("grant", {62'd0, grant}, win_wr ? 64'd1 : 64'd2);
        check_eq("cmd_valid", {63'd0, ctl_cmd_valid}, 64'd1);
        check_eq("cmd_write", {63'd0, ctl_cmd_write}, {63'd0, win_wr});
        check_eq("cmd_addr", {42'd0, ctl_cmd_addr}, {42'd0, exp_addr});

        if (win_wr) m_starve = 0;
        else if (wr && m_starve < LIMIT) m_starve++;
        m_last_wr = win_wr;

        for (int k = 0; k < delay; k++) begin
            @(negedge clk_sdram);
            check_eq("cmd_hold", {41'd0, ctl_cmd_valid, ctl_cmd_addr}, {41'd1, exp_addr});
        end
        ctl_cmd_ready = 1;
        @(negedge clk_sdram);
        ctl_cmd_ready = 0;
        check_eq("cmd_drop", {63'd0, ctl_cmd_valid}, 64'd0);

        n = 0;
        cyc = 0;
        if (win_wr) begin
            while (n < BL && cyc < 200) begin
                v = ($urandom_range(0, 2) != 0) || (cyc > 20);
                d = DW'($urandom);
                wr_data = d;
                ctl_wr_data_ack = v;
                #1;
                check_eq("wr_pass", {47'd0, wr_data_ack, ctl_wr_data}, {47'd0, v, d});
                @(negedge clk_sdram);
                cyc++;
                if (v) n++;
                check_eq("wr_done", {63'd0, wr_done}, {63'd0, (n == BL)});
            end
            ctl_wr_data_ack = 0;
        end else begin
            while (n < BL && cyc < 200) begin
                v = ($urandom_range(0, 2) != 0) || (cyc > 20);
                d = DW'($urandom);
                ctl_rd_data_valid = v;
                ctl_rd_data = d;
                @(negedge clk_sdram);
                cyc++;
                if (v) n++;
                check_eq("rd_valid", {63'd0, rd_data_valid}, {63'd0, v});
                if (v) check_eq("rd_data", {48'd0, rd_data}, {48'd0, d});
                check_eq("rd_done", {62'd0, rd_done, wr_data_ack}, {62'd0, (n == BL), 1'b0});
                if (abort_words != 0 && n == abort_words) begin
                    ctl_rd_data_valid = 0;
                    rst = 1;
                    @(negedge clk_sdram);
                    rst = 0;
                    check_eq("abort_zero", out_bundle(), 64'd0);
                    m_starve  = 0;
                    m_last_wr = 1'b0;
                    return;
                end
            end
            ctl_rd_data_valid = 0;
        end
        check_eq("xfer_words", 64'(n), 64'(BL));
        @(negedge clk_sdram);
        check_eq("back_idle", {59'd0, grant, wr_done, rd_done, rd_data_valid}, 64'd0);
        check_eq("no_perr", {63'd0, protocol_err}, 64'd0);
    endtask

    initial begin
        drive_idle();
        rst = 1;
        repeat (3) @(negedge clk_sdram);
        rst = 0;
        check_eq("reset", out_bundle(), 64'd0);

        run_burst(0, 1, 0, 0, 0);
        run_burst(1, 0, 0, 5, 0);

        do_reset("reset_rr");
        for (int i = 0; i < 4; i++) run_burst(1, 1, 0, 0, 0);

        do_reset("reset_urg");
        for (int i = 0; i < 6; i++) run_burst(1, 1, 1, 1, 0);

        for (int i = 0; i < 40; i++) begin
            bit w, r;
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if (!w && !r) r = 1;
            run_burst(w, r, $urandom_range(0, 3) != 0, $urandom_range(0, 3), 0);
        end

        run_burst(0, 1, 0, 1, 3);
        run_burst(1, 1, 0, 0, 0);
        run_burst(1, 1, 0, 2, 0);

        ctl_rd_data_valid = 1;
        ctl_rd_data = 16'hbeef;
        @(negedge clk_sdram);
        ctl_rd_data_valid = 0;
        check_eq("perr_rd", {62'd0, protocol_err, rd_data_valid}, 64'd2);
        @(negedge clk_sdram);
        check_eq("perr_sticky", {62'd0, protocol_err, rd_data_valid}, 64'd2);
        do_reset("perr_clear");

        ctl_wr_data_ack = 1;
        #1;
        check_eq("stray_ack", {63'd0, wr_data_ack}, 64'd0);
        @(negedge clk_sdram);
        ctl_wr_data_ack = 0;
        check_eq("perr_wr", {63'd0, protocol_err}, 64'd1);
        do_reset("perr_clear2");
        run_burst(1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
